// File: rtl/mux_n_stream.sv
`default_nettype none
// ============================================================================
// Module   : mux_n_stream
// Summary  : N-to-1 packet-locked stream multiplexer with a packet counter.
//            Define MUX_N_STREAM_OREG_EN for a registered 2-entry skid output.
// Revision : 1.0 - initial release
// ============================================================================
module mux_n_stream #(
   parameter int C_WIDTH = 8,
   parameter int C_NUM   = 4,
   localparam int C_SEL_W = (C_NUM > 1) ? $clog2(C_NUM) : 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [C_NUM*C_WIDTH-1:0]   s_data,
   input  logic [C_NUM-1:0]           s_valid,
   input  logic [C_NUM-1:0]           s_last,
   output logic [C_NUM-1:0]           s_ready,
   input  logic [C_SEL_W-1:0]         sel,
   output logic [C_WIDTH-1:0]         m_data,
   output logic                       m_valid,
   output logic                       m_last,
   input  logic                       m_ready,
   output logic [C_SEL_W-1:0]         cur_sel,
   output logic                       busy,
   output logic [15:0]                pkt_cnt
);

   localparam int c_sel_span = 1 << C_SEL_W;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_LOCK = 1'b1
   } state_t;

   state_t               r_state;
   logic [C_SEL_W-1:0]   r_cur_sel;
   logic [15:0]          r_pkt_cnt;

   logic [c_sel_span-1:0] w_valid_pad;
   logic                  w_sel_hit;
   logic [C_WIDTH-1:0]    w_cur_data;
   logic                  w_cur_valid;
   logic                  w_cur_last;
   logic                  w_in_ready;
   logic                  w_xfer;

   // Padding s_valid to the full select span keeps out-of-range selects harmless.
   always_comb begin
      w_valid_pad = '0;
      w_valid_pad[C_NUM-1:0] = s_valid;
      w_sel_hit = (int'(sel) < C_NUM) && w_valid_pad[sel];
   end

   always_comb begin
      w_cur_data  = '0;
      w_cur_valid = 1'b0;
      w_cur_last  = 1'b0;
      for (int k = 0; k < C_NUM; k++) begin
         if (r_cur_sel == C_SEL_W'(k)) begin
            w_cur_data  = s_data[k*C_WIDTH +: C_WIDTH];
            w_cur_valid = s_valid[k];
            w_cur_last  = s_last[k];
         end
      end
   end

   assign w_xfer = (r_state == ST_LOCK) && w_cur_valid && w_in_ready;

   always_comb begin
      s_ready = '0;
      for (int k = 0; k < C_NUM; k++)
         s_ready[k] = (r_state == ST_LOCK) && (r_cur_sel == C_SEL_W'(k)) && w_in_ready;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_cur_sel <= '0;
         r_pkt_cnt <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_sel_hit) begin
                  r_cur_sel <= sel;
                  r_state   <= ST_LOCK;
               end
            end
            ST_LOCK: begin
               if (w_xfer && w_cur_last) begin
                  r_state   <= ST_IDLE;
                  r_pkt_cnt <= r_pkt_cnt + 16'd1;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

`ifdef MUX_N_STREAM_OREG_EN
   logic [C_WIDTH-1:0] r_hd_data;
   logic               r_hd_valid;
   logic               r_hd_last;
   logic [C_WIDTH-1:0] r_sk_data;
   logic               r_sk_valid;
   logic               r_sk_last;

   // The skid entry only fills when the head is stalled, so "full" is just r_sk_valid.
   assign w_in_ready = ~r_sk_valid;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_hd_data  <= '0;
         r_hd_valid <= 1'b0;
         r_hd_last  <= 1'b0;
         r_sk_data  <= '0;
         r_sk_valid <= 1'b0;
         r_sk_last  <= 1'b0;
      end else if (!r_hd_valid || m_ready) begin
         if (r_sk_valid) begin
            r_hd_data  <= r_sk_data;
            r_hd_valid <= 1'b1;
            r_hd_last  <= r_sk_last;
            r_sk_valid <= 1'b0;
         end else begin
            r_hd_data  <= w_cur_data;
            r_hd_valid <= w_xfer;
            r_hd_last  <= w_cur_last;
         end
      end else if (w_xfer) begin
         r_sk_data  <= w_cur_data;
         r_sk_valid <= 1'b1;
         r_sk_last  <= w_cur_last;
      end
   end

   assign m_data  = r_hd_data;
   assign m_valid = r_hd_valid;
   assign m_last  = r_hd_last;
`else
   assign w_in_ready = m_ready;
   assign m_data     = w_cur_data;
   assign m_valid    = (r_state == ST_LOCK) && w_cur_valid;
   assign m_last     = w_cur_last;
`endif

   assign cur_sel = r_cur_sel;
   assign busy    = (r_state == ST_LOCK);
   assign pkt_cnt = r_pkt_cnt;

endmodule
`default_nettype wire

// File: doc/mux_n_stream.md
MUX_N_STREAM -- requirements
Module: mux_n_stream

Interface
REQ-001 Parameter C_WIDTH, default 8, is the data width of every channel in bits.
REQ-002 Parameter C_NUM, default 4, is the input channel count, legal range 2..16.
REQ-003 Localparam C_SEL_W = max(1, clog2(C_NUM)) is the select width.
REQ-004 clk  in  1  is the single clock; all logic is on the rising edge.
REQ-005 rst  in  1  is a synchronous, active-high reset.
REQ-006 s_data  in  C_NUM*C_WIDTH  carries the channel data; channel k occupies bits [k*C_WIDTH +: C_WIDTH].
REQ-007 s_valid  in  C_NUM  is the per-channel beat valid.
REQ-008 s_last  in  C_NUM  is the per-channel end-of-packet flag.
REQ-009 s_ready  out  C_NUM  is the per-channel ready.
REQ-010 sel  in  C_SEL_W  is the requested channel, sampled only in IDLE.
REQ-011 m_data  out  C_WIDTH  is the output data.
REQ-012 m_valid / m_last  out  1 / 1  are the output beat valid and end-of-packet flag.
REQ-013 m_ready  in  1  is the downstream ready.
REQ-014 cur_sel  out  C_SEL_W  is the locked channel.
REQ-015 busy  out  1  is high while in LOCK.
REQ-016 pkt_cnt  out  16  counts completed packets, wrapping modulo 2^16.

Function
REQ-017 A beat transfers on an interface in any cycle where valid and ready are both 1.
REQ-018 The FSM shall have two states: IDLE and LOCK.
REQ-019 IDLE: all s_ready bits are 0; if sel < C_NUM and s_valid[sel]=1, then cur_sel<=sel and the state moves to LOCK at the next edge.
REQ-020 IDLE with sel >= C_NUM: no lock occurs, the state stays IDLE, and no error is flagged.
REQ-021 LOCK: only s_ready[cur_sel] may be 1; it equals the output stage's accept condition. All other s_ready bits are 0.
REQ-022 LOCK: sel changes are ignored; cur_sel is held until packet end.
REQ-023 An accepted input beat with s_last[cur_sel]=1 returns the state to IDLE at the next edge and increments pkt_cnt by 1 (0xFFFF wraps to 0x0000).
REQ-024 Switching takes exactly one IDLE cycle between packets; no beat of another channel is interleaved inside a packet.
REQ-025 m_data and m_last shall be the unmodified data and last of the accepted input beats, in order, with no loss or duplication.
REQ-026 m_valid=0 implies m_data and m_last are don't-care; the bench shall not check them.
REQ-027 Single-beat packets (valid and last on the first beat) are legal; the sequence is lock cycle, transfer cycle, then IDLE.
REQ-028 Holding m_ready=0 stalls the locked channel without dropping beats; s_valid on non-locked channels has no effect.

Reset
REQ-029 While rst=1 at a clock edge: state <= IDLE, cur_sel <= 0, pkt_cnt <= 0, the output stage is emptied, m_valid=0, busy=0, and s_ready=0.
REQ-030 Reset mid-packet discards in-flight beats and does not increment pkt_cnt; the next lock starts from IDLE.

Configuration
REQ-031 Macro MUX_N_STREAM_OREG_EN, when defined, inserts a 2-entry skid buffer:
- m_data, m_valid and m_last are driven from registers.
- Accept latency is 1 cycle.
- Full throughput of 1 beat per cycle under continuous m_ready.
- s_ready[cur_sel] = buffer not full (registered).
- The FSM may return to IDLE and relock while the buffer drains.
REQ-032 MUX_N_STREAM_OREG_EN undefined: the output path is combinational.
- m_data = channel cur_sel data; m_valid = LOCK & s_valid[cur_sel]; s_ready[cur_sel] = LOCK & m_ready.
- Latency is 0 cycles.

Verification
REQ-033 Reset mid-packet: C_NUM=4, lock channel 2, transfer 3 of 5 beats, assert rst for 1 cycle.
- Required: m_valid=0, busy=0, and pkt_cnt=0 the following cycle.
- Required: a new packet on channel 0 then completes intact.
REQ-034 Held packet: sel=1, channel 1 sends 4 beats (0x11..0x14, last on 0x14) while m_ready=1 and sel switches to 3 mid-packet.
- Required: m_data output is 0x11,0x12,0x13,0x14; m_last only on 0x14; pkt_cnt=1.
- Required: channel 3 is not locked until one IDLE cycle after the packet.
REQ-035 Backpressure: m_ready toggles 1/0 every cycle during a 6-beat packet.
- Required: all 6 beats are delivered in order with none dropped.
- Required: s_ready[cur_sel]=0 on every cycle where a beat cannot be accepted.
REQ-036 Out-of-range select: C_NUM=3, sel=3, all s_valid=1 for 10 cycles.
- Required: busy stays 0, all s_ready stay 0, and m_valid stays 0.
REQ-037 pkt_cnt wrap: preload with 65535 single-beat packets, then send 1 more.
- Required: pkt_cnt=0xFFFF, then 0x0000.
REQ-038 Throughput with MUX_N_STREAM_OREG_EN defined: continuous 8-beat packet with m_ready=1.
- Required: 8 consecutive m_valid cycles, first beat 1 cycle after the input accept.
